// File: rtl/fpf_decoder_03_if.sv
// Valid/ready bus bundle for the 3-wire FPF decoder: codeword stream in,
// decoded value stream out.
interface fpf_decoder_03_if #(
    parameter int unsigned FBLEN = 3
);
    logic [2:0]       codein;
    logic             codein_valid;
    logic             codein_ready;
    logic [FBLEN-1:0] dataout;
    logic             dataout_valid;
    logic             dataout_ready;
    logic             code_err;

    modport master (
        output codein, codein_valid, dataout_ready,
        input  codein_ready, dataout, dataout_valid, code_err
    );

    modport slave (
        input  codein, codein_valid, dataout_ready,
        output codein_ready, dataout, dataout_valid, code_err
    );
endinterface

// File: rtl/fpf_decoder_03.sv
// Receive-side FPF (Fibonacci) codeword decoder: two-stage valid/ready pipeline
// with forbidden-pattern detection and saturating error statistics.
module fpf_decoder_03 #(
    parameter int unsigned CNT_W         = 8,
    parameter bit          FLAG_NONCANON = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    fpf_decoder_03_if.slave  bus,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_count,
    input  logic             err_clear
);
    localparam int unsigned FBLEN03 = 3;
    // Fibonacci weights for bit 0, 1, 2.
    localparam logic [FBLEN03-1:0] FNS01 = FBLEN03'(1);
    localparam logic [FBLEN03-1:0] FNS02 = FBLEN03'(1);
    localparam logic [FBLEN03-1:0] FNS03 = FBLEN03'(2);

    logic [2:0]         s1_code;
    logic               s1_v;
    logic [FBLEN03-1:0] data_q;
    logic               err_q;
    logic               valid_q;

    logic               out_xfer;
    logic               s2_load;
    logic               in_xfer;
    logic               err_evt;
    logic [FBLEN03-1:0] dec;
    logic               dec_err;

    always_comb begin
        out_xfer         = valid_q & bus.dataout_ready;
        s2_load          = s1_v & (~valid_q | bus.dataout_ready);
        bus.codein_ready = ~s1_v | s2_load;
        in_xfer          = bus.codein_valid & bus.codein_ready;
        err_evt          = out_xfer & err_q;
    end

    always_comb begin
        dec = (s1_code[2] ? FNS03 : '0)
            + (s1_code[1] ? FNS02 : '0)
            + (s1_code[0] ? FNS01 : '0);
        dec_err = (s1_code == 3'b010) | (s1_code == 3'b101)
                | (FLAG_NONCANON & (s1_code == 3'b100));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_code <= '0;
            s1_v    <= 1'b0;
        end else if (in_xfer) begin
            s1_code <= bus.codein;
            s1_v    <= 1'b1;
        end else if (s2_load) begin
            s1_v    <= 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
        end else if (s2_load) begin
            data_q  <= dec;
            err_q   <= dec_err;
            valid_q <= 1'b1;
        end else if (out_xfer) begin
            valid_q <= 1'b0;
        end
    end

    // A clear coinciding with an error transfer still counts that error.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_sticky <= 1'b0;
            err_count  <= '0;
        end else if (err_clear) begin
            err_sticky <= err_evt;
            err_count  <= err_evt ? CNT_W'(1) : '0;
        end else if (err_evt) begin
            err_sticky <= 1'b1;
            if (err_count != '1) begin
                err_count <= err_count + CNT_W'(1);
            end
        end
    end

    assign bus.dataout       = data_q;
    assign bus.code_err      = err_q;
    assign bus.dataout_valid = valid_q;
endmodule

// File: tb/tb_fpf_decoder_03.sv
// Directed and random bench for fpf_decoder_03: two instances (flagging and
// non-flagging, 8- and 2-bit counters) share one stimulus stream.
module tb_fpf_decoder_03;
    logic       clock = 1'b0;
    logic       reset;
    logic       err_clear;
    logic       err_sticky_a, err_sticky_b;
    logic [7:0] err_count_a;
    logic [1:0] err_count_b;

    fpf_decoder_03_if bus_a ();
    fpf_decoder_03_if bus_b ();

    assign bus_b.codein        = bus_a.codein;
    assign bus_b.codein_valid  = bus_a.codein_valid;
    assign bus_b.dataout_ready = bus_a.dataout_ready;

    fpf_decoder_03 #(.CNT_W(8), .FLAG_NONCANON(1'b1)) u_dut_a (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus_a),
        .err_sticky (err_sticky_a),
        .err_count  (err_count_a),
        .err_clear  (err_clear)
    );

    fpf_decoder_03 #(.CNT_W(2), .FLAG_NONCANON(1'b0)) u_dut_b (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus_b),
        .err_sticky (err_sticky_b),
        .err_count  (err_count_b),
        .err_clear  (err_clear)
    );

    always #5 clock = ~clock;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         n_out   = 0;
    logic [4:0] exp_q [$];   // {err_a, err_b, data}
    logic [7:0] m_cnt_a;
    logic [1:0] m_cnt_b;
    logic       m_stk_a, m_stk_b;
    logic       dv_seen;
    logic [2:0] data_seen;
    logic       acc;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] ref_decode(input logic [2:0] c);
        return (c[2] ? 3'd2 : 3'd0) + (c[1] ? 3'd1 : 3'd0) + (c[0] ? 3'd1 : 3'd0);
    endfunction

    function automatic logic ref_err(input logic [2:0] c, input logic flag);
        return (c == 3'b010) || (c == 3'b101) || (flag && c == 3'b100);
    endfunction

    task automatic clear_model();
        exp_q.delete();
        m_cnt_a = '0;
        m_cnt_b = '0;
        m_stk_a = 1'b0;
        m_stk_b = 1'b0;
    endtask

    // One clock: check state at negedge, drive inputs, predict the posedge.
    task automatic cycle(input logic v, input logic [2:0] c, input logic dr, input logic clr,
                         output logic accepted);
        logic       ox, ea, eb, exp_rdy;
        logic [4:0] e;
        int         q, s1v;
        @(negedge clock);
        dv_seen   = bus_a.dataout_valid;
        data_seen = bus_a.dataout;
        check_val("cnt_a", err_count_a, m_cnt_a);
        check_val("cnt_b", err_count_b, m_cnt_b);
        check_val("sticky_a", err_sticky_a, m_stk_a);
        check_val("sticky_b", err_sticky_b, m_stk_b);
        bus_a.codein_valid  = v;
        bus_a.codein        = c;
        bus_a.dataout_ready = dr;
        err_clear           = clr;
        #1;
        q   = exp_q.size();
        if (q == 0) check_val("idle_dv", bus_a.dataout_valid, 0);
        s1v = q - int'(bus_a.dataout_valid);
        exp_rdy = (s1v == 0) || !bus_a.dataout_valid || dr;
        check_val("ready", bus_a.codein_ready, exp_rdy);
        accepted = v & bus_a.codein_ready;
        ox = bus_a.dataout_valid & dr;
        ea = 1'b0;
        eb = 1'b0;
        if (ox) begin
            if (q == 0) begin
                check_val("spurious_out", bus_a.dataout_valid, 0);
            end else begin
                e = exp_q.pop_front();
                check_val("data_a", bus_a.dataout, e[2:0]);
                check_val("data_b", bus_b.dataout, e[2:0]);
                check_val("err_a", bus_a.code_err, e[4]);
                check_val("err_b", bus_b.code_err, e[3]);
                ea = e[4];
                eb = e[3];
                n_out++;
            end
        end
        if (accepted) exp_q.push_back({ref_err(c, 1'b1), ref_err(c, 1'b0), ref_decode(c)});
        if (clr) begin
            m_cnt_a = ea ? 8'd1 : 8'd0;
            m_cnt_b = eb ? 2'd1 : 2'd0;
            m_stk_a = ea;
            m_stk_b = eb;
        end else begin
            if (ea) begin
                m_stk_a = 1'b1;
                if (m_cnt_a != 8'hff) m_cnt_a = m_cnt_a + 8'd1;
            end
            if (eb) begin
                m_stk_b = 1'b1;
                if (m_cnt_b != 2'b11) m_cnt_b = m_cnt_b + 2'd1;
            end
        end
    endtask

    task automatic settle();
        logic a;
        cycle(1'b0, 3'b000, 1'b1, 1'b0, a);
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin
            settle();
            guard++;
        end
        check_val("drain", exp_q.size(), 0);
        settle();
    endtask

    logic [2:0] codes [5];
    logic [2:0] exp_d [5];
    logic [2:0] bp_codes [3];

    initial begin
        reset               = 1'b1;
        err_clear           = 1'b0;
        bus_a.codein        = 3'b000;
        bus_a.codein_valid  = 1'b1;
        bus_a.dataout_ready = 1'b1;
        clear_model();
        #1;
        check_val("rst_dv", bus_a.dataout_valid, 0);
        check_val("rst_data", bus_a.dataout, 0);
        check_val("rst_err", bus_a.code_err, 0);
        repeat (2) @(negedge clock);
        bus_a.codein_valid = 1'b0;
        reset = 1'b0;
        #1;
        check_val("rst_ready", bus_a.codein_ready, 1);

        // Legal codes streamed back to back.
        codes = '{3'b000, 3'b001, 3'b011, 3'b110, 3'b111};
        exp_d = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
        for (int j = 0; j < 9; j++) begin
            cycle(j < 5, (j < 5) ? codes[j] : 3'b000, 1'b1, 1'b0, acc);
            check_val("stream_dv", dv_seen, (j >= 2 && j <= 6));
            if (j >= 2 && j <= 6) check_val("stream_data", data_seen, exp_d[j-2]);
        end
        drain();
        check_val("stream_cnt", err_count_a, 0);

        // Illegal and non-canonical codes.
        codes[0] = 3'b010;
        codes[1] = 3'b101;
        codes[2] = 3'b100;
        for (int j = 0; j < 3; j++) cycle(1'b1, codes[j], 1'b1, 1'b0, acc);
        drain();
        check_val("err_cnt_a", err_count_a, 3);
        check_val("err_stk_a", err_sticky_a, 1);
        check_val("err_cnt_b", err_count_b, 2);

        // Backpressure: two accepts, then ready drops while output holds.
        bp_codes = '{3'b001, 3'b011, 3'b110};
        begin
            int i = 0;
            int guard = 0;
            for (int k = 0; k < 4; k++) begin
                cycle(1'b1, bp_codes[i], 1'b0, 1'b0, acc);
                check_val("bp_acc", acc, (k < 2));
                if (k >= 2) check_val("bp_hold", data_seen, 1);
                if (acc) i++;
            end
            while (i < 3 && guard < 10) begin
                cycle(1'b1, bp_codes[i], 1'b1, 1'b0, acc);
                if (acc) i++;
                guard++;
            end
            check_val("bp_sent", i, 3);
        end
        drain();

        // Saturation of the 2-bit counter and clear behaviour.
        cycle(1'b0, 3'b000, 1'b1, 1'b1, acc);
        settle();
        check_val("clr_cnt_b", err_count_b, 0);
        check_val("clr_stk_b", err_sticky_b, 0);
        for (int j = 0; j < 5; j++) cycle(1'b1, 3'b010, 1'b1, 1'b0, acc);
        drain();
        check_val("sat_cnt_b", err_count_b, 3);
        check_val("sat_cnt_a", err_count_a, 5);
        cycle(1'b1, 3'b010, 1'b1, 1'b0, acc);
        settle();
        cycle(1'b0, 3'b000, 1'b1, 1'b1, acc);
        settle();
        check_val("clrx_cnt_b", err_count_b, 1);
        check_val("clrx_stk_b", err_sticky_b, 1);
        check_val("clrx_cnt_a", err_count_a, 1);
        cycle(1'b0, 3'b000, 1'b1, 1'b1, acc);
        settle();
        check_val("clr2_cnt_b", err_count_b, 0);
        check_val("clr2_stk_b", err_sticky_b, 0);

        // Async reset with two words in flight.
        cycle(1'b1, 3'b010, 1'b1, 1'b0, acc);
        drain();
        cycle(1'b1, 3'b101, 1'b1, 1'b0, acc);
        cycle(1'b1, 3'b011, 1'b0, 1'b0, acc);
        cycle(1'b0, 3'b000, 1'b0, 1'b0, acc);
        check_val("inflight_dv", dv_seen, 1);
        @(negedge clock);
        bus_a.codein_valid = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check_val("arst_dv", bus_a.dataout_valid, 0);
        check_val("arst_data", bus_a.dataout, 0);
        check_val("arst_cnt", err_count_a, 0);
        clear_model();
        repeat (2) @(negedge clock);
        bus_a.codein_valid = 1'b0;
        reset = 1'b0;
        for (int j = 0; j < 5; j++) begin
            cycle(j == 0, 3'b111, 1'b1, 1'b0, acc);
            check_val("post_dv", dv_seen, (j == 2));
            if (j == 2) check_val("post_data", data_seen, 4);
        end

        // Random valid/ready traffic against the scoreboard.
        begin
            int sent = 0;
            int guard = 0;
            while ((sent < 1000 || exp_q.size() != 0) && guard < 20000) begin
                cycle((sent < 1000) && ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                      $urandom_range(0, 2) != 0, $urandom_range(0, 63) == 0, acc);
                if (acc) sent++;
                guard++;
            end
            check_val("rand_sent", sent, 1000);
            check_val("rand_left", exp_q.size(), 0);
            settle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
